pspin_her_ctx_sched: RTL and testbench

Round-robin scheduler that shares the single HER output toward the PsPIN wrapper among NUM_CTX per-handler-context HER request streams. Enforces a per-context in-flight credit limit: a HER consumes one credit when issued and returns it when PsPIN feedback for that context arrives. Sits between the per-context HER sources and the wrapper HER port. Also exposes in-flight counts and error/stall statistics to ctrl_regs.

---
 rtl/pspin_her_ctx_sched.sv | 205 ++++++++++++++++++++
 tb/tb_pspin_her_ctx_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_her_ctx_sched.sv
// Round-robin arbiter sharing one HER output among NUM_CTX handler contexts,
// with a per-context in-flight credit limit returned by PsPIN feedback.
module pspin_her_ctx_sched #(
    parameter int NUM_CTX      = 4,
    parameter int CTX_ID_WIDTH = $clog2(NUM_CTX),
    parameter int ADDR_WIDTH   = 32,
    parameter int MSG_ID_WIDTH = 10,
    parameter int CREDIT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [NUM_CTX*CREDIT_WIDTH-1:0] cfg_credit_limit,
    input  logic                            cfg_valid,

    input  logic [NUM_CTX-1:0]              s_her_valid,
    output logic [NUM_CTX-1:0]              s_her_ready,
    input  logic [NUM_CTX*ADDR_WIDTH-1:0]   s_her_addr,
    input  logic [NUM_CTX*ADDR_WIDTH-1:0]   s_her_size,
    input  logic [NUM_CTX*MSG_ID_WIDTH-1:0] s_her_msgid,
    input  logic [NUM_CTX-1:0]              s_her_is_eom,

    output logic                            m_her_valid,
    input  logic                            m_her_ready,
    output logic [ADDR_WIDTH-1:0]           m_her_addr,
    output logic [ADDR_WIDTH-1:0]           m_her_size,
    output logic [MSG_ID_WIDTH-1:0]         m_her_msgid,
    output logic                            m_her_is_eom,
    output logic [CTX_ID_WIDTH-1:0]         m_her_ctx,

    input  logic                            fb_valid,
    output logic                            fb_ready,
    input  logic [CTX_ID_WIDTH-1:0]         fb_ctx,

    output logic [NUM_CTX*CREDIT_WIDTH-1:0] inflight_cnt,
    output logic                            fb_err,
    output logic [31:0]                     stall_cycles
);

    logic [CREDIT_WIDTH-1:0] limit_q    [NUM_CTX];
    logic [CREDIT_WIDTH-1:0] limit_d    [NUM_CTX];
    logic [CREDIT_WIDTH-1:0] inflight_q [NUM_CTX];
    logic [CREDIT_WIDTH-1:0] inflight_d [NUM_CTX];

    logic [CTX_ID_WIDTH-1:0] rr_q, rr_d;
    logic                    fb_err_q, fb_err_d;
    logic [31:0]             stall_q, stall_d;
    logic                    fb_ready_q;

    logic                    m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [ADDR_WIDTH-1:0]   m_size_q, m_size_d;
    logic [MSG_ID_WIDTH-1:0] m_msgid_q, m_msgid_d;
    logic                    m_eom_q, m_eom_d;
    logic [CTX_ID_WIDTH-1:0] m_ctx_q, m_ctx_d;

    logic [NUM_CTX-1:0]      eligible;
    logic                    slot_free;
    logic                    grant_valid;
    logic [CTX_ID_WIDTH-1:0] grant_idx;
    logic                    fb_in_range;
    logic                    fb_dec_ok;

    assign slot_free   = !m_valid_q || m_her_ready;
    assign fb_in_range = int'(fb_ctx) < NUM_CTX;
    assign fb_dec_ok   = fb_valid && fb_in_range && (inflight_q[fb_ctx] != '0);

    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            eligible[i] = s_her_valid[i] && (inflight_q[i] < limit_q[i]);
        end
    end

    // First eligible context at or after the round-robin pointer.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CTX; k++) begin
            idx = (int'(rr_q) + k) % NUM_CTX;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CTX_ID_WIDTH'(idx);
            end
        end
        if (!slot_free) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        s_her_ready = '0;
        if (grant_valid) begin
            s_her_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_size_d  = m_size_q;
        m_msgid_d = m_msgid_q;
        m_eom_d   = m_eom_q;
        m_ctx_d   = m_ctx_q;
        if (slot_free) begin
            m_valid_d = grant_valid;
            if (grant_valid) begin
                m_addr_d  = s_her_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_size_d  = s_her_size[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_msgid_d = s_her_msgid[int'(grant_idx)*MSG_ID_WIDTH +: MSG_ID_WIDTH];
                m_eom_d   = s_her_is_eom[grant_idx];
                m_ctx_d   = grant_idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (int'(grant_idx) == NUM_CTX - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Grant and feedback on the same context cancel out.
    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            inflight_d[i] = inflight_q[i];
            if (grant_valid && (int'(grant_idx) == i)) begin
                inflight_d[i] = inflight_d[i] + 1'b1;
            end
            if (fb_dec_ok && (int'(fb_ctx) == i)) begin
                inflight_d[i] = inflight_d[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            limit_d[i] = cfg_valid ? cfg_credit_limit[i*CREDIT_WIDTH +: CREDIT_WIDTH] : limit_q[i];
        end
    end

    always_comb begin
        fb_err_d = fb_err_q;
        if (fb_valid && !fb_dec_ok) begin
            fb_err_d = 1'b1;
        end
        stall_d = stall_q;
        if ((|s_her_valid) && slot_free && !(|eligible) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                limit_q[i]    <= '0;
                inflight_q[i] <= '0;
            end
            rr_q       <= '0;
            fb_err_q   <= 1'b0;
            stall_q    <= '0;
            fb_ready_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_size_q   <= '0;
            m_msgid_q  <= '0;
            m_eom_q    <= 1'b0;
            m_ctx_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                limit_q[i]    <= limit_d[i];
                inflight_q[i] <= inflight_d[i];
            end
            rr_q       <= rr_d;
            fb_err_q   <= fb_err_d;
            stall_q    <= stall_d;
            fb_ready_q <= 1'b1;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_size_q   <= m_size_d;
            m_msgid_q  <= m_msgid_d;
            m_eom_q    <= m_eom_d;
            m_ctx_q    <= m_ctx_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            inflight_cnt[i*CREDIT_WIDTH +: CREDIT_WIDTH] = inflight_q[i];
        end
    end

    assign m_her_valid  = m_valid_q;
    assign m_her_addr   = m_addr_q;
    assign m_her_size   = m_size_q;
    assign m_her_msgid  = m_msgid_q;
    assign m_her_is_eom = m_eom_q;
    assign m_her_ctx    = m_ctx_q;
    assign fb_ready     = fb_ready_q;
    assign fb_err       = fb_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pspin_her_ctx_sched.sv
// Scoreboard bench for pspin_her_ctx_sched: a per-cycle credit/round-robin model
// predicts grants; a monitor checks the wrapper-side HER stream against the queue.
module tb_pspin_her_ctx_sched;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int AW = 32;
    localparam int MW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*CW-1:0]   cfg_credit_limit = '0;
    logic              cfg_valid = 1'b0;
    logic [N-1:0]      s_her_valid = '0;
    logic [N-1:0]      s_her_ready;
    logic [N*AW-1:0]   s_her_addr = '0;
    logic [N*AW-1:0]   s_her_size = '0;
    logic [N*MW-1:0]   s_her_msgid = '0;
    logic [N-1:0]      s_her_is_eom = '0;
    logic              m_her_valid;
    logic              m_her_ready = 1'b0;
    logic [AW-1:0]     m_her_addr;
    logic [AW-1:0]     m_her_size;
    logic [MW-1:0]     m_her_msgid;
    logic              m_her_is_eom;
    logic [1:0]        m_her_ctx;
    logic              fb_valid = 1'b0;
    logic              fb_ready;
    logic [1:0]        fb_ctx = '0;
    logic [N*CW-1:0]   inflight_cnt;
    logic              fb_err;
    logic [31:0]       stall_cycles;

    pspin_her_ctx_sched #(
        .NUM_CTX(N), .ADDR_WIDTH(AW), .MSG_ID_WIDTH(MW), .CREDIT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_credit_limit(cfg_credit_limit), .cfg_valid(cfg_valid),
        .s_her_valid(s_her_valid), .s_her_ready(s_her_ready),
        .s_her_addr(s_her_addr), .s_her_size(s_her_size),
        .s_her_msgid(s_her_msgid), .s_her_is_eom(s_her_is_eom),
        .m_her_valid(m_her_valid), .m_her_ready(m_her_ready),
        .m_her_addr(m_her_addr), .m_her_size(m_her_size),
        .m_her_msgid(m_her_msgid), .m_her_is_eom(m_her_is_eom), .m_her_ctx(m_her_ctx),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_ctx(fb_ctx),
        .inflight_cnt(inflight_cnt), .fb_err(fb_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] size;
        logic [MW-1:0] msgid;
        logic          eom;
        logic [1:0]    ctx;
    } her_t;

    her_t   exp_q[$];
    int     checks   = 0;
    int     failures = 0;

    // Reference state: credits, limits, arbitration pointer, sticky error, stall count.
    int     lim  [N];
    int     infl [N];
    int     rr;
    bit     err_m;
    longint stall_m;
    bit     pushed_now = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            lim[i]  = 0;
            infl[i] = 0;
        end
        rr      = 0;
        err_m   = 1'b0;
        stall_m = 0;
        exp_q.delete();
    endtask

    task automatic check_regs();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("inflight[%0d]", i), longint'(inflight_cnt[i*CW +: CW]), infl[i]);
        end
        chk("fb_err", longint'(fb_err), longint'(err_m));
        chk("stall_cycles", longint'(stall_cycles), stall_m);
        chk("fb_ready", longint'(fb_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        s_her_valid = '0;
        m_her_ready = 1'b0;
        fb_valid    = 1'b0;
        cfg_valid   = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset m_her_valid", longint'(m_her_valid), 0);
        chk("reset s_her_ready", longint'(s_her_ready), 0);
        chk("reset inflight", longint'(inflight_cnt), 0);
        chk("reset stall", longint'(stall_cycles), 0);
        chk("reset fb_err", longint'(fb_err), 0);
    endtask

    // One clock of stimulus; the model advances to the post-edge state.
    task automatic step(input logic [N-1:0] v, input bit mr, input bit fbv, input int fbc,
                        input bit cfgv, input logic [N*CW-1:0] cfg);
        int  g;
        bit  slot_free;
        bit  dec_ok;
        logic [N-1:0] exp_rdy;
        her_t h;
        @(negedge clk);
        check_regs();
        pushed_now = 1'b0;
        s_her_valid = v;
        for (int i = 0; i < N; i++) begin
            s_her_addr[i*AW +: AW]  = $urandom();
            s_her_size[i*AW +: AW]  = $urandom();
            s_her_msgid[i*MW +: MW] = MW'($urandom());
            s_her_is_eom[i]         = 1'($urandom());
        end
        m_her_ready      = mr;
        fb_valid         = fbv;
        fb_ctx           = 2'(fbc);
        cfg_valid        = cfgv;
        cfg_credit_limit = cfg;
        #1;
        slot_free = (exp_q.size() == 0) || mr;
        g = -1;
        if (slot_free) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (g < 0 && v[c] && infl[c] < lim[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("s_her_ready", longint'(s_her_ready), longint'(exp_rdy));
        if (g >= 0) begin
            h.addr  = s_her_addr[g*AW +: AW];
            h.size  = s_her_size[g*AW +: AW];
            h.msgid = s_her_msgid[g*MW +: MW];
            h.eom   = s_her_is_eom[g];
            h.ctx   = 2'(g);
            exp_q.push_back(h);
            pushed_now = 1'b1;
            rr = (g + 1) % N;
        end
        if ((|v) && slot_free && g < 0 && stall_m < 64'hFFFF_FFFF) stall_m++;
        dec_ok = 1'b0;
        if (fbv) begin
            if (infl[fbc] > 0) dec_ok = 1'b1;
            else err_m = 1'b1;
        end
        if (g >= 0) infl[g]++;
        if (dec_ok) infl[fbc]--;
        if (cfgv) begin
            for (int i = 0; i < N; i++) lim[i] = int'(cfg[i*CW +: CW]);
        end
    endtask

    task automatic idle(input logic [N-1:0] v, input bit mr, input int n);
        for (int i = 0; i < n; i++) step(v, mr, 1'b0, 0, 1'b0, '0);
    endtask

    // Monitor: wrapper-side stream against the scoreboard queue.
    initial begin
        her_t h;
        int   pending;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                pending = exp_q.size() - int'(pushed_now);
                chk("m_her_valid", longint'(m_her_valid), longint'(pending > 0));
                if (m_her_valid && pending > 0) begin
                    h = exp_q[0];
                    chk("m_her_addr", longint'(m_her_addr), longint'(h.addr));
                    chk("m_her_size", longint'(m_her_size), longint'(h.size));
                    chk("m_her_msgid", longint'(m_her_msgid), longint'(h.msgid));
                    chk("m_her_is_eom", longint'(m_her_is_eom), longint'(h.eom));
                    chk("m_her_ctx", longint'(m_her_ctx), longint'(h.ctx));
                    if (m_her_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // All limits 4, everyone valid: 0,1,2,3 round robin until all saturate.
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd4, 8'd4, 8'd4, 8'd4});
        idle(4'hF, 1'b1, 22);

        // Single credit on ctx0; feedback releases a second HER.
        do_reset();
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd1});
        idle(4'h1, 1'b1, 4);
        step(4'h1, 1'b1, 1'b1, 0, 1'b0, '0);
        idle(4'h1, 1'b1, 3);

        // Backpressure while ctx2 is on the output, then release.
        do_reset();
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd4, 8'd4, 8'd4, 8'd4});
        idle(4'hF, 1'b1, 3);
        idle(4'hF, 1'b0, 5);
        idle(4'hF, 1'b1, 3);

        // ctx1 at 2 of 3: simultaneous grant and feedback nets to zero.
        do_reset();
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd3, 8'd3, 8'd3, 8'd3});
        idle(4'h2, 1'b1, 2);
        step(4'h2, 1'b1, 1'b1, 1, 1'b0, '0);
        idle(4'h0, 1'b1, 2);

        // Feedback for an idle context sets the sticky error.
        step(4'h0, 1'b1, 1'b1, 3, 1'b0, '0);
        idle(4'h0, 1'b1, 3);

        // Lower ctx0 limit below its in-flight count, drain with feedback.
        do_reset();
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd4, 8'd4, 8'd4, 8'd4});
        idle(4'h1, 1'b1, 3);
        step(4'h1, 1'b1, 1'b0, 0, 1'b1, {8'd4, 8'd4, 8'd4, 8'd1});
        idle(4'h1, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            step(4'h1, 1'b1, 1'b1, 0, 1'b0, '0);
            idle(4'h1, 1'b1, 1);
        end
        idle(4'h1, 1'b1, 2);

        // Random traffic with occasional reconfig and one mid-run reset.
        do_reset();
        step('0, 1'b1, 1'b0, 0, 1'b1, {8'd3, 8'd2, 8'd4, 8'd1});
        for (int n = 0; n < 600; n++) begin
            logic [N*CW-1:0] cfg;
            bit cfgv;
            if (n == 300) begin
                do_reset();
                step('0, 1'b1, 1'b0, 0, 1'b1, {8'd2, 8'd5, 8'd1, 8'd3});
            end
            cfgv = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) cfg[i*CW +: CW] = CW'($urandom_range(0, 5));
            step(N'($urandom()), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, N-1), cfgv, cfg);
        end

        idle(4'h0, 1'b1, 4);
        chk("scoreboard drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
